// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - two-stage cook program sequencer driving a button-pulse countdown timer
module cook_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_valid,
    input  logic [9:0] time1,
    input  logic [9:0] time2,
    output logic       prog_ready,
    input  logic       door_open,
    input  logic       cancel,
    output logic       t_tenMinutes,
    output logic       t_minute,
    output logic       t_tenSeconds,
    output logic       t_second,
    output logic       t_pause,
    output logic       t_start,
    input  logic [9:0] t_countDown,
    input  logic       t_finish,
    output logic       busy,
    output logic [1:0] stage,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_START,
        S_RUN,
        S_HOLD
    } state_t;

    state_t     state_q;
    logic [9:0] rem_q;
    logic [9:0] time2_q;
    logic       fin_armed_q;   // a low t_finish has been seen in the current RUN stretch
    logic [3:0] btn_q;         // {ten_minutes, minute, ten_seconds, second}
    logic       pause_q;
    logic       start_q;
    logic       busy_q;
    logic       ready_q;
    logic       done_q;
    logic [1:0] stage_q;

    // The timer count is status only; the sequencer never steers on it.
    logic unused_countdown;
    assign unused_countdown = ^t_countDown;

    // Largest button that fits in the remaining time, and the time left after pressing it.
    // Only called with r >= 1.
    function automatic logic [13:0] press_step(input logic [9:0] r);
        if (r >= 10'd600)
            return {4'b1000, r - 10'd600};
        else if (r >= 10'd60)
            return {4'b0100, r - 10'd60};
        else if (r >= 10'd10)
            return {4'b0010, r - 10'd10};
        else
            return {4'b0001, r - 10'd1};
    endfunction

    // Sequencer FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            time2_q     <= '0;
            fin_armed_q <= 1'b0;
            btn_q       <= '0;
            pause_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            stage_q     <= 2'd0;
        end else begin
            btn_q   <= '0;
            pause_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (prog_valid && !cancel) begin
                    time2_q <= time2;
                    if (time1 != 10'd0) begin
                        {btn_q, rem_q} <= press_step(time1);
                        state_q        <= S_PRESS;
                        stage_q        <= 2'd1;
                        busy_q         <= 1'b1;
                        ready_q        <= 1'b0;
                    end else if (time2 != 10'd0) begin
                        // Empty first stage: go straight into stage 2.
                        {btn_q, rem_q} <= press_step(time2);
                        state_q        <= S_PRESS;
                        stage_q        <= 2'd2;
                        busy_q         <= 1'b1;
                        ready_q        <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end else if (cancel) begin
                pause_q     <= 1'b1;
                state_q     <= S_IDLE;
                rem_q       <= '0;
                fin_armed_q <= 1'b0;
                busy_q      <= 1'b0;
                ready_q     <= 1'b1;
                stage_q     <= 2'd0;
            end else begin
                case (state_q)
                    S_PRESS: begin
                        state_q <= S_GAP;
                    end
                    S_GAP: begin
                        if (rem_q == 10'd0) begin
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end else begin
                            {btn_q, rem_q} <= press_step(rem_q);
                            state_q        <= S_PRESS;
                        end
                    end
                    S_START: begin
                        state_q     <= S_RUN;
                        fin_armed_q <= 1'b0;
                    end
                    S_RUN: begin
                        if (door_open) begin
                            pause_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else if (t_finish && fin_armed_q) begin
                            fin_armed_q <= 1'b0;
                            if (stage_q == 2'd1 && time2_q != 10'd0) begin
                                {btn_q, rem_q} <= press_step(time2_q);
                                stage_q        <= 2'd2;
                                state_q        <= S_PRESS;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                                rem_q   <= '0;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                                stage_q <= 2'd0;
                            end
                        end else if (!t_finish) begin
                            fin_armed_q <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (!door_open) begin
                            start_q     <= 1'b1;
                            state_q     <= S_RUN;
                            fin_armed_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        stage_q <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign t_tenMinutes = btn_q[3];
    assign t_minute     = btn_q[2];
    assign t_tenSeconds = btn_q[1];
    assign t_second     = btn_q[0];
    assign t_pause      = pause_q;
    assign t_start      = start_q;
    assign busy         = busy_q;
    assign stage        = stage_q;
    assign done         = done_q;
    assign prog_ready   = ready_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// tb/tb_cook_sequencer.sv - scoreboard bench for cook_sequencer
module tb_cook_sequencer;

    localparam int EV_TENMIN = 0;
    localparam int EV_MIN    = 1;
    localparam int EV_TENSEC = 2;
    localparam int EV_SEC    = 3;
    localparam int EV_PAUSE  = 4;
    localparam int EV_START  = 5;
    localparam int EV_DONE   = 6;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_valid = 1'b0;
    logic [9:0] time1 = '0;
    logic [9:0] time2 = '0;
    logic       prog_ready;
    logic       door_open = 1'b0;
    logic       cancel = 1'b0;
    logic       t_tenMinutes, t_minute, t_tenSeconds, t_second, t_pause, t_start;
    logic [9:0] t_countDown = '0;
    logic       t_finish = 1'b0;
    logic       busy;
    logic [1:0] stage;
    logic       done;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    cook_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .prog_valid   (prog_valid),
        .time1        (time1),
        .time2        (time2),
        .prog_ready   (prog_ready),
        .door_open    (door_open),
        .cancel       (cancel),
        .t_tenMinutes (t_tenMinutes),
        .t_minute     (t_minute),
        .t_tenSeconds (t_tenSeconds),
        .t_second     (t_second),
        .t_pause      (t_pause),
        .t_start      (t_start),
        .t_countDown  (t_countDown),
        .t_finish     (t_finish),
        .busy         (busy),
        .stage        (stage),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every observed pulse must be the next expected event, on the expected cycle.
    always @(negedge clk) begin
        logic [6:0] ev;
        int         code;
        ev_t        e;
        if (mon_en) begin
            ev = {done, t_start, t_pause, t_second, t_tenSeconds, t_minute, t_tenMinutes};
            if (ev != 7'd0) begin
                vectors++;
                code = -1;
                for (int i = 0; i < 7; i++) if (ev[i]) code = i;
                if ($countones(ev) != 1) begin
                    miscompares++;
                    $display("FAIL one_pulse cyc=%0d got pulses=%b required exactly one", cyc, ev);
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d got code=%0d required none", cyc, code);
                end else begin
                    e = exp_q.pop_front();
                    if (code !== e.code || cyc !== e.cyc) begin
                        miscompares++;
                        $display("FAIL pulse got code=%0d cyc=%0d required code=%0d cyc=%0d",
                                 code, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_ev(input int code, input int c);
        exp_q.push_back('{code: code, cyc: c});
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present a program on a negedge; acceptance cycle index is returned.
    task automatic offer(input logic [9:0] a, input logic [9:0] b, output int c0);
        @(negedge clk);
        c0 = cyc;
        vectors++;
        if (prog_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_offer got %b required 1", prog_ready);
        end
        time1      = a;
        time2      = b;
        prog_valid = 1'b1;
    endtask

    task automatic release_prog();
        @(negedge clk);
        prog_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, stage, done, prog_ready, t_tenMinutes, t_minute, t_tenSeconds, t_second, t_pause, t_start} !== 11'b00001000000) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b stage=%0d done=%b ready=%b required 0 0 0 1",
                     busy, stage, done, prog_ready);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_stage();
        int c0;
        offer(10'd75, 10'd0, c0);
        push_ev(EV_MIN, c0 + 1);
        push_ev(EV_TENSEC, c0 + 3);
        for (int k = 0; k < 5; k++) push_ev(EV_SEC, c0 + 5 + 2 * k);
        push_ev(EV_START, c0 + 15);
        push_ev(EV_DONE, c0 + 19);
        release_prog();
        go_to(c0 + 16);
        vectors++;
        if ({busy, stage, prog_ready} !== 4'b1010) begin
            miscompares++;
            $display("FAIL s1_run_status got busy=%b stage=%0d ready=%b required 1 1 0", busy, stage, prog_ready);
        end
        go_to(c0 + 18);
        t_finish = 1'b1;
        go_to(c0 + 19);
        t_finish = 1'b0;
        go_to(c0 + 20);
        vectors++;
        if ({busy, stage, prog_ready} !== 4'b0001 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL s1_end got busy=%b stage=%0d ready=%b pending=%0d required 0 0 1 0",
                     busy, stage, prog_ready, exp_q.size());
        end
    endtask

    task automatic test_zero_program();
        int c0;
        offer(10'd0, 10'd0, c0);
        push_ev(EV_DONE, c0 + 1);
        release_prog();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_busy got %b required 0", busy);
        end
        go_to(c0 + 2);
        vectors++;
        if (prog_ready !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_end got ready=%b pending=%0d required 1 0", prog_ready, exp_q.size());
        end
    endtask

    task automatic test_two_stage();
        int c0;
        offer(10'd610, 10'd5, c0);
        push_ev(EV_TENMIN, c0 + 1);
        push_ev(EV_TENSEC, c0 + 3);
        push_ev(EV_START, c0 + 5);
        for (int k = 0; k < 5; k++) push_ev(EV_SEC, c0 + 9 + 2 * k);
        push_ev(EV_START, c0 + 19);
        push_ev(EV_DONE, c0 + 27);
        release_prog();
        time2 = 10'd300;
        go_to(c0 + 8);
        t_finish = 1'b1;
        go_to(c0 + 10);
        vectors++;
        if (stage !== 2'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL s2_stage got stage=%0d busy=%b required 2 1", stage, busy);
        end
        // t_finish stays high across stage-2 RUN entry and must not complete it.
        go_to(c0 + 24);
        t_finish = 1'b0;
        go_to(c0 + 26);
        t_finish = 1'b1;
        go_to(c0 + 27);
        t_finish = 1'b0;
        go_to(c0 + 28);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL s2_end got busy=%b pending=%0d required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_stage1_skip();
        int c0;
        offer(10'd0, 10'd7, c0);
        for (int k = 0; k < 7; k++) push_ev(EV_SEC, c0 + 1 + 2 * k);
        push_ev(EV_START, c0 + 15);
        push_ev(EV_DONE, c0 + 19);
        release_prog();
        vectors++;
        if (stage !== 2'd2) begin
            miscompares++;
            $display("FAIL skip_stage got %0d required 2", stage);
        end
        go_to(c0 + 18);
        t_finish = 1'b1;
        go_to(c0 + 19);
        t_finish = 1'b0;
        go_to(c0 + 20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL skip_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_door();
        int c0;
        offer(10'd3, 10'd0, c0);
        for (int k = 0; k < 3; k++) push_ev(EV_SEC, c0 + 1 + 2 * k);
        push_ev(EV_START, c0 + 7);
        push_ev(EV_PAUSE, c0 + 11);
        push_ev(EV_START, c0 + 15);
        push_ev(EV_DONE, c0 + 20);
        release_prog();
        go_to(c0 + 4);
        door_open = 1'b1;
        go_to(c0 + 7);
        door_open = 1'b0;
        go_to(c0 + 10);
        door_open = 1'b1;
        go_to(c0 + 12);
        t_finish = 1'b1;
        go_to(c0 + 13);
        vectors++;
        if (busy !== 1'b1 || stage !== 2'd1) begin
            miscompares++;
            $display("FAIL hold_status got busy=%b stage=%0d required 1 1", busy, stage);
        end
        go_to(c0 + 14);
        door_open = 1'b0;
        go_to(c0 + 17);
        t_finish = 1'b0;
        go_to(c0 + 19);
        t_finish = 1'b1;
        go_to(c0 + 20);
        t_finish = 1'b0;
        go_to(c0 + 21);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL door_end got busy=%b pending=%0d required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_cancel();
        int c0;
        int c1;
        offer(10'd25, 10'd0, c0);
        push_ev(EV_TENSEC, c0 + 1);
        push_ev(EV_PAUSE, c0 + 3);
        release_prog();
        go_to(c0 + 2);
        cancel = 1'b1;
        go_to(c0 + 3);
        cancel = 1'b0;
        go_to(c0 + 4);
        vectors++;
        if ({busy, stage, prog_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL cancel_idle got busy=%b stage=%0d ready=%b required 0 0 1", busy, stage, prog_ready);
        end
        // Cancel held in IDLE blocks acceptance.
        @(negedge clk);
        c1 = cyc;
        time1      = 10'd5;
        time2      = 10'd0;
        prog_valid = 1'b1;
        cancel     = 1'b1;
        @(negedge clk);
        prog_valid = 1'b0;
        cancel     = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_blocks got busy=%b required 0", busy);
        end
        go_to(c1 + 4);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cancel_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_program();
        int c0;
        offer(10'd25, 10'd0, c0);
        push_ev(EV_TENSEC, c0 + 1);
        release_prog();
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({busy, stage, done, prog_ready, t_tenMinutes, t_minute, t_tenSeconds, t_second, t_pause, t_start} !== 11'b00001000000) begin
            miscompares++;
            $display("FAIL async_reset got busy=%b stage=%0d tensec=%b ready=%b required 0 0 0 1",
                     busy, stage, t_tenSeconds, prog_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || prog_ready !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset got busy=%b ready=%b pending=%0d required 0 1 0",
                     busy, prog_ready, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        offer(10'd0, 10'd0, c0);
        push_ev(EV_DONE, c0 + 1);
        push_ev(EV_SEC, c0 + 2);
        push_ev(EV_SEC, c0 + 4);
        push_ev(EV_START, c0 + 6);
        push_ev(EV_DONE, c0 + 10);
        @(negedge clk);
        time1 = 10'd2;
        @(negedge clk);
        prog_valid = 1'b0;
        go_to(c0 + 9);
        t_finish = 1'b1;
        go_to(c0 + 10);
        t_finish = 1'b0;
        go_to(c0 + 11);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_end got busy=%b pending=%0d required 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_stage();
        test_zero_program();
        test_two_stage();
        test_stage1_skip();
        test_door();
        test_cancel();
        test_reset_mid_program();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 The block SHALL have these ports, in this order (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-004 prog_valid  in  1  a two-stage cook program is offered this cycle.
REQ-005 time1  in  10  stage-1 duration in seconds, unsigned.
REQ-006 time2  in  10  stage-2 duration in seconds, unsigned; 0 means no stage 2.
REQ-007 prog_ready  out  1  high only in IDLE; a program is accepted on the edge where prog_valid and prog_ready are both 1.
REQ-008 door_open  in  1  level; 1 = oven door open.
REQ-009 cancel  in  1  level; aborts the program.
REQ-010 t_tenMinutes, t_minute, t_tenSeconds, t_second, t_pause, t_start  out  1 each  button pulses to the countdown timer.
REQ-011 t_countDown  in  10  timer remaining count; status only, not used for control.
REQ-012 t_finish  in  1  timer finished flag.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 stage  out  2  0 idle, 1 stage 1 active, 2 stage 2 active.
REQ-015 done  out  1  one-cycle pulse on normal program completion.

Function
REQ-016 The block SHALL latch time1 and time2 on acceptance; later input changes SHALL have no effect on that program.
REQ-017 States SHALL be IDLE, PRESS, GAP, START, RUN and HOLD.
REQ-018 Stage entry SHALL load rem = the stage time and go to PRESS; a stage with time 0 SHALL be skipped with no pulses.
REQ-019 In PRESS, exactly one button SHALL be high for one cycle, chosen by priority: rem>=600 gives t_tenMinutes and rem-=600; else rem>=60 gives t_minute and rem-=60; else rem>=10 gives t_tenSeconds and rem-=10; else rem>=1 gives t_second and rem-=1.
REQ-020 Each PRESS cycle SHALL be followed by one GAP cycle with all buttons low.
REQ-021 After a GAP with rem==0, the next cycle SHALL be START: t_start high for one cycle, then RUN.
REQ-022 The first press pulse SHALL appear in the cycle immediately after acceptance (or after stage entry).
REQ-023 RUN SHALL complete the stage on a rising edge of t_finish (sampled 0 then 1 within RUN); a t_finish level that is already high on RUN entry SHALL NOT complete the stage.
REQ-024 On completion of stage 1, the block SHALL enter stage 2 if the latched time2 != 0; otherwise it SHALL pulse done and go to IDLE. Completion of stage 2 SHALL pulse done and go to IDLE.
REQ-025 door_open=1 in RUN SHALL give a one-cycle t_pause pulse and a move to HOLD.
REQ-026 In HOLD, door_open=0 SHALL give a one-cycle t_start pulse and a return to RUN; the rising-edge detector SHALL be re-armed.
REQ-027 door_open=1 during PRESS, GAP or START SHALL be ignored until RUN is entered.
REQ-028 cancel=1 in any non-IDLE state SHALL give a one-cycle t_pause pulse and a move to IDLE, with no done pulse. Cancel SHALL take priority over door_open and t_finish in the same cycle.
REQ-029 cancel=1 in IDLE SHALL block acceptance of a program that cycle.
REQ-030 Acceptance with time1=0 and time2=0 SHALL give done high in the next cycle, no button pulses, then IDLE.
REQ-031 All outputs SHALL be registered, and at most one button output SHALL be high in any cycle.

Reset
REQ-032 rst=0 SHALL immediately force IDLE: all button outputs 0, done 0, busy 0, stage 0, prog_ready 1, rem 0, edge detector cleared.
REQ-033 Reset mid-program SHALL discard the program; the block SHALL issue no pulses after reset release until a new acceptance.

Verification
REQ-034 time1=75, time2=0 -> one t_minute, one t_tenSeconds, five t_second pulses on cycles 1,3,5,...,13 after acceptance; t_start on cycle 15; after t_finish rises, done pulses once and the block returns to IDLE.
REQ-035 time1=0, time2=0 -> done on the cycle after acceptance; no button pulses; prog_ready=1 the cycle after that.
REQ-036 time1=610, time2=5 -> stage 1 gives one t_tenMinutes and one t_tenSeconds pulse, then t_start; after t_finish, stage becomes 2 and gives five t_second pulses, then t_start; done pulses only after the second t_finish.
REQ-037 door_open rises in RUN -> one t_pause pulse, HOLD, t_finish ignored; door_open falls -> one t_start pulse; a later t_finish rise completes the stage.
REQ-038 cancel asserted during GAP -> one t_pause pulse, IDLE, no done; then rst=0 asserted mid-PRESS -> all outputs 0 at once and no pulses after release.
